// File: rtl/regfile_arb_pkg.sv
// Shared types, default sizes and the one-hot decoder for the register-file write arbiter.
package regfile_arb_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 1;
  localparam int DEF_ADDR_W   = 4;
  localparam int ONEHOT_MAX   = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Indices at or beyond ONEHOT_MAX decode to all zeros.
  function automatic logic [ONEHOT_MAX-1:0] onehot_decode(input logic [7:0] idx);
    logic [ONEHOT_MAX-1:0] vec;
    vec = '0;
    if (int'(idx) < ONEHOT_MAX) vec[idx[3:0]] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic               valid,
  output logic [PTR_W-1:0]   winner
);

  // Scan farthest offset first so the closest request to ptr overwrites the rest.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % NUM_REQ]) begin
        valid  = 1'b1;
        winner = PTR_W'((int'(ptr) + off) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing one register-bank write port; registered outputs.
// Optional owner lock enabled by defining REGFILE_ARB_LOCK_EN.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] reqAddr,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
`ifdef REGFILE_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        reqLock,
`endif
  input  logic                      stall,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       regWriteEnable,
  output logic [DATA_W-1:0]         regWriteData,
  output logic                      addrErr
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                addr_err_q, addr_err_d;

  logic [NUM_REQ-1:0]  pick_req;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [ADDR_W-1:0]   win_addr;
  logic                lock_hold;
  logic                fire;

`ifdef REGFILE_ARB_LOCK_EN
  logic [PTR_W-1:0] owner_q, owner_d;

  // Lock persists only while the owner keeps both req and reqLock high.
  assign lock_hold = (state_q == ST_LOCKED) && req[owner_q] && reqLock[owner_q];
  assign pick_req  = lock_hold ? (req & NUM_REQ'(onehot_decode(8'(owner_q)))) : req;
`else
  assign lock_hold = 1'b0;
  assign pick_req  = req;
`endif

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (pick_req),
    .ptr    (ptr_q),
    .valid  (pick_vld),
    .winner (pick_idx)
  );

  assign win_addr = reqAddr[int'(pick_idx)*ADDR_W +: ADDR_W];
  assign fire     = pick_vld && !stall;

  always_comb begin
    state_d    = ST_IDLE;
    ptr_d      = ptr_q;
    gnt_d      = '0;
    we_d       = '0;
    wdata_d    = wdata_q;
    addr_err_d = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
    owner_d    = owner_q;
    if (lock_hold && !fire) state_d = ST_LOCKED;
`endif
    if (fire) begin
      state_d = ST_GRANT;
      gnt_d   = NUM_REQ'(onehot_decode(8'(pick_idx)));
      wdata_d = reqData[int'(pick_idx)*DATA_W +: DATA_W];
      if (int'(win_addr) < NUM_REGS) begin
        we_d = NUM_REGS'(onehot_decode(8'(win_addr)));
      end else begin
        addr_err_d = 1'b1;
      end
      if (!lock_hold) begin
        ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
      end
`ifdef REGFILE_ARB_LOCK_EN
      if (reqLock[pick_idx]) begin
        state_d = ST_LOCKED;
        owner_d = pick_idx;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      we_q       <= '0;
      wdata_q    <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      addr_err_q <= addr_err_d;
    end
  end

`ifdef REGFILE_ARB_LOCK_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) owner_q <= '0;
    else         owner_q <= owner_d;
  end
`endif

  // An IDLE state never carries a grant; qualify the pulses with it.
  assign gnt            = (state_q == ST_IDLE) ? '0 : gnt_q;
  assign regWriteEnable = (state_q == ST_IDLE) ? '0 : we_q;
  assign addrErr        = (state_q == ST_IDLE) ? 1'b0 : addr_err_q;
  assign regWriteData   = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with default parameters (4 requesters, 8 registers).
module tb_regfile_write_arbiter;

  logic        clock;
  logic        resetN;
  logic [3:0]  req;
  logic [15:0] reqAddr;
  logic [3:0]  reqData;
  logic        stall;
  logic [3:0]  gnt;
  logic [7:0]  regWriteEnable;
  logic [0:0]  regWriteData;
  logic        addrErr;
`ifdef REGFILE_ARB_LOCK_EN
  logic [3:0]  reqLock;
`endif

  int checks;
  int failures;

  regfile_write_arbiter dut (
    .clock          (clock),
    .resetN         (resetN),
    .req            (req),
    .reqAddr        (reqAddr),
    .reqData        (reqData),
`ifdef REGFILE_ARB_LOCK_EN
    .reqLock        (reqLock),
`endif
    .stall          (stall),
    .gnt            (gnt),
    .regWriteEnable (regWriteEnable),
    .regWriteData   (regWriteData),
    .addrErr        (addrErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
    check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check("we_onehot", 32'($countones(regWriteEnable) <= 1), 32'd1);
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [7:0] we,
                            input logic wd, input logic err);
    check({tag, "_gnt"}, 32'(gnt), 32'(g));
    check({tag, "_we"}, 32'(regWriteEnable), 32'(we));
    check({tag, "_wd"}, 32'(regWriteData), 32'(wd));
    check({tag, "_err"}, 32'(addrErr), 32'(err));
  endtask

  logic [3:0] fair_gnt [8];
  logic [7:0] fair_we  [8];
  logic       fair_wd  [8];
  int         gcount   [4];

  initial begin
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    req      = '0;
    reqAddr  = '0;
    reqData  = '0;
    stall    = 1'b0;
`ifdef REGFILE_ARB_LOCK_EN
    reqLock  = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    expect_out("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    resetN = 1'b1;

    // Grant once (advances ptr), then reset mid-cycle.
    req     = 4'b1111;
    reqAddr = 16'h3210;
    reqData = 4'b1010;
    tick();
    expect_out("pre_rst", 4'b0001, 8'h01, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    expect_out("pre_rst2", 4'b0010, 8'h02, 1'b1, 1'b0);
    #2;
    resetN = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 8'h00, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    expect_out("held_rst", 4'b0000, 8'h00, 1'b0, 1'b0);
    resetN = 1'b1;

    // Fairness: after reset ptr=0, so the sequence starts at requester 0.
    fair_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    fair_we  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08};
    fair_wd  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    gcount   = '{0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out($sformatf("fair%0d", i), fair_gnt[i], fair_we[i], fair_wd[i], 1'b0);
      for (int r = 0; r < 4; r++) if (gnt[r]) gcount[r]++;
    end
    for (int r = 0; r < 4; r++) check($sformatf("fair_count%0d", r), 32'(gcount[r]), 32'd2);

    req = 4'b0000;
    tick();
    expect_out("idle_hold", 4'b0000, 8'h00, 1'b1, 1'b0);

    // Single write: requester 2, addr 5, data 1 (ptr=0).
    req     = 4'b0100;
    reqAddr = 16'h0500;
    reqData = 4'b0100;
    tick();
    expect_out("single", 4'b0100, 8'b0010_0000, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("single_after", 4'b0000, 8'h00, 1'b1, 1'b0);
    tick();
    expect_out("single_idle", 4'b0000, 8'h00, 1'b1, 1'b0);

    // Stall: ptr=3; requesters 0 (addr 6, data 0) and 1 (addr 7, data 1).
    req     = 4'b0011;
    reqAddr = 16'h0076;
    reqData = 4'b0010;
    stall   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 4'b0000, 8'h00, 1'b1, 1'b0);
    end
    stall = 1'b0;
    tick();
    expect_out("unstall0", 4'b0001, 8'b0100_0000, 1'b0, 1'b0);
    req = 4'b0010;
    tick();
    expect_out("unstall1", 4'b0010, 8'b1000_0000, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("unstall_idle", 4'b0000, 8'h00, 1'b1, 1'b0);

    // Address error: requester 1, addr 9, then addr 8 (first out-of-range value).
    req     = 4'b0010;
    reqAddr = 16'h0090;
    reqData = 4'b0000;
    tick();
    expect_out("addr9", 4'b0010, 8'h00, 1'b0, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("addr9_after", 4'b0000, 8'h00, 1'b0, 1'b0);
    req     = 4'b0010;
    reqAddr = 16'h0080;
    reqData = 4'b0010;
    tick();
    expect_out("addr8", 4'b0010, 8'h00, 1'b1, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("addr8_after", 4'b0000, 8'h00, 1'b1, 1'b0);

    // Sole requester granted back-to-back: requester 3, addr 4, data 0.
    req     = 4'b1000;
    reqAddr = 16'h4000;
    reqData = 4'b0000;
    tick();
    expect_out("b2b0", 4'b1000, 8'b0001_0000, 1'b0, 1'b0);
    tick();
    expect_out("b2b1", 4'b1000, 8'b0001_0000, 1'b0, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("b2b_idle", 4'b0000, 8'h00, 1'b0, 1'b0);

`ifdef REGFILE_ARB_LOCK_EN
    // Lock: ptr=0; requester 0 (addr 1) locks out requester 3 (addr 2).
    req     = 4'b1001;
    reqAddr = 16'h2001;
    reqData = 4'b1000;
    reqLock = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("lock%0d", i), 4'b0001, 8'h02, 1'b0, 1'b0);
    end
    reqLock = 4'b0000;
    tick();
    expect_out("unlock", 4'b1000, 8'h04, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
